regfile_scoreboard: RTL and testbench

//  Parametrised register file with NUM_READ read ports, one write port and a per-register

---
 rtl/regfile_scoreboard_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 107 ++++++++++
 tb/tb_regfile_scoreboard.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for regfile_scoreboard: write, reserve and read-port signals.
// The master side is decode/writeback, the slave side is the register file.
interface regfile_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic                           write_enable;
  logic [ADDR_WIDTH-1:0]          write_address;
  logic [DATA_WIDTH-1:0]          write_data;
  logic                           reserve_enable;
  logic [ADDR_WIDTH-1:0]          reserve_address;
  logic                           reserve_grant;
  logic [NUM_READ-1:0]            read_enable;
  logic [NUM_READ*ADDR_WIDTH-1:0] read_address;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data;
  logic [NUM_READ-1:0]            read_ready;
  logic                           stall;
  logic [ADDR_WIDTH:0]            busy_count;

  modport master (
    output write_enable, write_address, write_data,
    output reserve_enable, reserve_address,
    output read_enable, read_address,
    input  reserve_grant, read_data, read_ready, stall, busy_count
  );

  modport slave (
    input  write_enable, write_address, write_data,
    input  reserve_enable, reserve_address,
    input  read_enable, read_address,
    output reserve_grant, read_data, read_ready, stall, busy_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with NUM_READ combinational read ports, one write port and a busy scoreboard.
// Define REGFILE_SCOREBOARD_BYPASS_EN to forward same-cycle writeback data to matching reads.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input logic               clock,
  input logic               reset,
  regfile_scoreboard_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_ONE = 1;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [ADDR_WIDTH:0]   busy_count_q;

  logic write_hit;
  logic reserve_ok;
  logic reserve_hit;
  logic count_inc;
  logic count_dec;

  // A reserve is allowed when the target is free or is being released by this cycle's writeback.
  always_comb begin
    write_hit   = bus.write_enable && (bus.write_address != '0);
    reserve_ok  = (bus.reserve_address == '0) || !busy[bus.reserve_address] ||
                  (bus.write_enable && (bus.write_address == bus.reserve_address));
    reserve_hit = !reset && bus.reserve_enable && reserve_ok && (bus.reserve_address != '0);
    count_inc   = reserve_hit && !busy[bus.reserve_address];
    count_dec   = write_hit && busy[bus.write_address] &&
                  !(reserve_hit && (bus.reserve_address == bus.write_address));
  end

  assign bus.reserve_grant = !reset && bus.reserve_enable && reserve_ok;
  assign bus.busy_count    = busy_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[bus.write_address] <= bus.write_data;
    end
  end

  // The reserve update comes last so a same-address write+reserve leaves the register busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (write_hit) begin
        busy[bus.write_address] <= 1'b0;
      end
      if (reserve_hit) begin
        busy[bus.reserve_address] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_count_q <= '0;
    end else if (count_inc && !count_dec) begin
      busy_count_q <= busy_count_q + COUNT_ONE;
    end else if (count_dec && !count_inc) begin
      busy_count_q <= busy_count_q - COUNT_ONE;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    logic                  forward;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    assign addr = bus.read_address[p*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef REGFILE_SCOREBOARD_BYPASS_EN
    assign forward = write_hit && (bus.write_address == addr);
`else
    assign forward = 1'b0;
`endif

    // Disabled ports, register 0 and reset all read as zero and ready.
    always_comb begin
      data  = '0;
      ready = 1'b1;
      if (!reset && bus.read_enable[p] && (addr != '0)) begin
        if (forward) begin
          data  = bus.write_data;
          ready = 1'b1;
        end else begin
          data  = regs[addr];
          ready = !busy[addr];
        end
      end
    end

    assign bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
    assign bus.read_ready[p]                         = ready;
  end

  assign bus.stall = |(bus.read_enable & ~bus.read_ready);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (NUM_READ=4): directed scenarios plus
// randomized traffic compared every cycle against an array-based model.
module tb_regfile_scoreboard;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int NREGS = 32;
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  bit [DW-1:0] model_regs [NREGS];
  bit          model_busy [NREGS];

  regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();

  regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [DW-1:0] portData(input int p);
    return bus.read_data[p*DW +: DW];
  endfunction

  // Model: expected outputs derived from the register/busy arrays and current inputs.
  function automatic bit expectGrant();
    int ra;
    ra = int'(bus.reserve_address);
    if (reset || !bus.reserve_enable) return 1'b0;
    return (ra == 0) || !model_busy[ra] ||
           (bus.write_enable && (int'(bus.write_address) == ra));
  endfunction

  function automatic bit isForwarded(input int a);
    return BYPASS && bus.write_enable && (int'(bus.write_address) == a);
  endfunction

  function automatic logic [DW-1:0] expectData(input int p);
    int a;
    a = int'(bus.read_address[p*AW +: AW]);
    if (reset || !bus.read_enable[p] || a == 0) return '0;
    if (isForwarded(a)) return bus.write_data;
    return model_regs[a];
  endfunction

  function automatic bit expectReady(input int p);
    int a;
    a = int'(bus.read_address[p*AW +: AW]);
    if (reset || !bus.read_enable[p] || a == 0) return 1'b1;
    if (isForwarded(a)) return 1'b1;
    return !model_busy[a];
  endfunction

  function automatic int expectCount();
    int n;
    n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(model_busy[i]);
    return n;
  endfunction

  // Model state update: writeback first, then the reserve on the same edge.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        model_regs[i] = '0;
        model_busy[i] = 1'b0;
      end
    end else begin
      bit g;
      g = expectGrant();
      if (bus.write_enable && bus.write_address != 0) begin
        model_regs[bus.write_address] = bus.write_data;
        model_busy[bus.write_address] = 1'b0;
      end
      if (g && bus.reserve_address != 0) model_busy[bus.reserve_address] = 1'b1;
    end
  end

  // Compare process: every negedge, all outputs against the model.
  always @(negedge clock) begin
    bit st;
    st = 1'b0;
    checkOutput("model grant", bus.reserve_grant, expectGrant());
    for (int p = 0; p < NR; p++) begin
      checkOutput($sformatf("model data%0d", p), portData(p), expectData(p));
      checkOutput($sformatf("model ready%0d", p), bus.read_ready[p], expectReady(p));
      st |= bus.read_enable[p] && !expectReady(p);
    end
    checkOutput("model stall", bus.stall, st);
    checkOutput("model busy_count", bus.busy_count, expectCount());
  end

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit we, input int wa, input logic [DW-1:0] wd,
                               input bit re, input int ra);
    bus.write_enable    = we;
    bus.write_address   = wa[AW-1:0];
    bus.write_data      = wd;
    bus.reserve_enable  = re;
    bus.reserve_address = ra[AW-1:0];
  endtask

  task automatic setRead(input int p, input bit en, input int a);
    bus.read_enable[p]          = en;
    bus.read_address[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic readsOff();
    for (int p = 0; p < NR; p++) setRead(p, 1'b0, 0);
  endtask

  initial begin
    applyStimulus(1'b0, 0, '0, 1'b1, 4);
    for (int p = 0; p < NR; p++) setRead(p, 1'b1, p + 1);
    #2;
    checkOutput("reset grant", bus.reserve_grant, 1'b0);
    checkOutput("reset data0", portData(0), 32'h0);
    checkOutput("reset ready", bus.read_ready, 4'hF);
    checkOutput("reset stall", bus.stall, 1'b0);
    checkOutput("reset count", bus.busy_count, 6'd0);
    #10 reset = 1'b0;
    readsOff();
    applyStimulus(1'b0, 0, '0, 1'b0, 0);

    // Scenario 1: write r5, then async reset mid-cycle clears it.
    nextCycle();
    applyStimulus(1'b1, 5, 32'hDEAD, 1'b0, 0);
    nextCycle();
    applyStimulus(1'b0, 0, '0, 1'b0, 0);
    setRead(0, 1'b1, 5);
    #1 checkOutput("r5 written", portData(0), 32'hDEAD);
    #1 reset = 1'b1;
    #1;
    checkOutput("async reset data0", portData(0), 32'h0);
    checkOutput("async reset count", bus.busy_count, 6'd0);
    checkOutput("async reset ready0", bus.read_ready[0], 1'b1);
    @(negedge clock);
    #1 reset = 1'b0;
    nextCycle();
    #1 checkOutput("r5 after reset", portData(0), 32'h0);

    // Scenario 2: reserve r3, stall, then writeback releases it.
    nextCycle();
    applyStimulus(1'b0, 0, '0, 1'b1, 3);
    setRead(0, 1'b1, 3);
    #1 checkOutput("reserve r3 grant", bus.reserve_grant, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, '0, 1'b0, 0);
    #1;
    checkOutput("r3 ready0", bus.read_ready[0], 1'b0);
    checkOutput("r3 stall", bus.stall, 1'b1);
    checkOutput("r3 count", bus.busy_count, 6'd1);
    nextCycle();
    applyStimulus(1'b1, 3, 32'h1234, 1'b0, 0);
    nextCycle();
    applyStimulus(1'b0, 0, '0, 1'b0, 0);
    #1;
    checkOutput("r3 released ready0", bus.read_ready[0], 1'b1);
    checkOutput("r3 released data0", portData(0), 32'h1234);
    checkOutput("r3 released count", bus.busy_count, 6'd0);

    // Scenario 3: second reserve of busy r7 is refused.
    nextCycle();
    readsOff();
    applyStimulus(1'b0, 0, '0, 1'b1, 7);
    #1 checkOutput("r7 first grant", bus.reserve_grant, 1'b1);
    nextCycle();
    #1;
    checkOutput("r7 second grant", bus.reserve_grant, 1'b0);
    checkOutput("r7 count", bus.busy_count, 6'd1);
    nextCycle();
    applyStimulus(1'b0, 0, '0, 1'b0, 0);
    #1 checkOutput("r7 count hold", bus.busy_count, 6'd1);

    // Scenario 4: same-cycle write and reserve of r7.
    nextCycle();
    applyStimulus(1'b1, 7, 32'h55, 1'b1, 7);
    #1;
    checkOutput("r7 wr+rsv grant", bus.reserve_grant, 1'b1);
    checkOutput("r7 wr+rsv count", bus.busy_count, 6'd1);
    nextCycle();
    applyStimulus(1'b0, 0, '0, 1'b0, 0);
    setRead(0, 1'b1, 7);
    #1;
    checkOutput("r7 data", portData(0), 32'h55);
    checkOutput("r7 still busy", bus.read_ready[0], 1'b0);
    checkOutput("r7 count after", bus.busy_count, 6'd1);

    // Scenario 5: read on port 1 during writeback of busy r9.
    nextCycle();
    readsOff();
    applyStimulus(1'b0, 0, '0, 1'b1, 9);
    #1 checkOutput("r9 grant", bus.reserve_grant, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 9, 32'hABCD, 1'b0, 0);
    setRead(1, 1'b1, 9);
    #1;
    checkOutput("r9 wb count", bus.busy_count, 6'd2);
    checkOutput("r9 wb data1", portData(1), BYPASS ? 32'hABCD : 32'h0);
    checkOutput("r9 wb ready1", bus.read_ready[1], BYPASS);
    checkOutput("r9 wb stall", bus.stall, !BYPASS);
    nextCycle();
    applyStimulus(1'b0, 0, '0, 1'b0, 0);
    #1;
    checkOutput("r9 next data1", portData(1), 32'hABCD);
    checkOutput("r9 next ready1", bus.read_ready[1], 1'b1);
    checkOutput("r9 next count", bus.busy_count, 6'd1);

    // Scenario 6: register 0 ignores write/reserve; four independent ports.
    nextCycle();
    readsOff();
    applyStimulus(1'b1, 0, 32'hFFFF, 1'b1, 0);
    setRead(0, 1'b1, 0);
    #1;
    checkOutput("r0 grant", bus.reserve_grant, 1'b1);
    checkOutput("r0 data0", portData(0), 32'h0);
    checkOutput("r0 ready0", bus.read_ready[0], 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, '0, 1'b0, 0);
    setRead(1, 1'b1, 7);
    setRead(2, 1'b1, 9);
    setRead(3, 1'b1, 3);
    #1;
    checkOutput("4p data0", portData(0), 32'h0);
    checkOutput("4p data1", portData(1), 32'h55);
    checkOutput("4p data2", portData(2), 32'hABCD);
    checkOutput("4p data3", portData(3), 32'h1234);
    checkOutput("4p ready", bus.read_ready, 4'b1101);
    checkOutput("4p stall", bus.stall, 1'b1);
    checkOutput("4p count", bus.busy_count, 6'd1);
    #1 setRead(1, 1'b0, 7);
    #1;
    checkOutput("port1 off data", portData(1), 32'h0);
    checkOutput("port1 off ready", bus.read_ready[1], 1'b1);
    checkOutput("port1 off stall", bus.stall, 1'b0);

    // Randomized traffic over a small address window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      nextCycle();
      applyStimulus($urandom_range(0, 1),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, NREGS-1) : $urandom_range(0, 7),
                    $urandom(),
                    $urandom_range(0, 1),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, NREGS-1) : $urandom_range(0, 7));
      for (int p = 0; p < NR; p++) setRead(p, $urandom_range(0, 3) != 0, $urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end

    nextCycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
